nfa_stream_sequencer: RTL and testbench

- Sequences a packetised byte stream into an array of NUM_ENG NFA engines and collects their sticky match flags.
- Drives the engines' shared sod/en and the byte passed to the char decoder.
- Detects each engine's first match per packet and queues one report per engine through a round-robin arbiter onto a valid/ready report port.
- Sits between the ingress byte FIFO and the match-report DMA.

---
 rtl/nfa_seq_pkg.sv | 24 ++
 rtl/nfa_rr_arbiter.sv | 30 +++
 rtl/nfa_stream_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_nfa_stream_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfa_seq_pkg.sv
// Shared types and constants for the NFA stream sequencer: FSM states,
// the byte fed to the engines while draining, and the report record.
package nfa_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    FLUSH
  } seq_state_t;

  localparam logic [7:0] DRAIN_CHAR = 8'h00;

  // Report fields are sized for the widest supported build; instances keep the low bits.
  localparam int REP_ID_MAX_W  = 8;
  localparam int REP_OFF_MAX_W = 32;

  typedef struct packed {
    logic [REP_ID_MAX_W-1:0]  eng_id;
    logic [REP_OFF_MAX_W-1:0] offset;
  } report_t;

endpackage

// File: rtl/nfa_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. The pointer itself is held by the parent.
module nfa_rr_arbiter #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  int j;

  // Scan from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_idx = W'(j);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nfa_stream_sequencer.sv
// Feeds packetised bytes to an NFA engine array, latches each engine's first
// match per packet and reports them round-robin on a valid/ready port.
// Optional build macro NFA_SEQ_MATCH_CNT_EN adds the pkt_match_cnt output.
module nfa_stream_sequencer #(
  parameter int NUM_ENG   = 8,
  parameter int OFF_W     = 16,
  parameter int DRAIN_CYC = 2,
  parameter int ID_W      = $clog2(NUM_ENG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  output logic               eng_sod,
  output logic               eng_en,
  output logic [7:0]         eng_char,
  input  logic [NUM_ENG-1:0] eng_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ID_W-1:0]    m_eng_id,
  output logic [OFF_W-1:0]   m_offset,
  output logic               pkt_done,
`ifdef NFA_SEQ_MATCH_CNT_EN
  output logic [ID_W:0]      pkt_match_cnt,
`endif
  output logic               busy
);

  import nfa_seq_pkg::*;

  localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  seq_state_t         state_reg, state_next;
  logic [OFF_W-1:0]   off_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [NUM_ENG-1:0] eng_out_q_reg;
  logic [NUM_ENG-1:0] pend_reg, pend_next;
  logic [OFF_W-1:0]   off_cap_reg [NUM_ENG];
  logic [ID_W-1:0]    rr_ptr_reg;
  logic               m_valid_reg;
  report_t            rep_reg;

  logic               detect;
  logic [NUM_ENG-1:0] rise;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               load;
  logic               issue;
  logic               unused_rep_bits;

  assign detect = (state_reg == RUN) || (state_reg == DRAIN);
  assign rise   = detect ? (eng_out & ~eng_out_q_reg) : '0;
  assign load   = ~m_valid_reg | m_ready;
  assign issue  = load & gnt_vld;

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    eng_sod    = 1'b0;
    eng_en     = 1'b0;
    eng_char   = s_data;
    pkt_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_valid) state_next = CLR;
      end
      CLR: begin
        eng_sod    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        eng_en  = s_valid;
        if (s_valid && s_last) state_next = (DRAIN_CYC == 0) ? FLUSH : DRAIN;
      end
      DRAIN: begin
        eng_en   = 1'b1;
        eng_char = DRAIN_CHAR;
        if (drain_cnt_reg <= DRAIN_W'(1)) state_next = FLUSH;
      end
      FLUSH: begin
        if (pend_reg == '0 && !m_valid_reg) begin
          pkt_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Engines are held clear for the whole reset and nothing is handshaken.
    if (rst) begin
      s_ready  = 1'b0;
      eng_en   = 1'b0;
      pkt_done = 1'b0;
      eng_sod  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      eng_out_q_reg <= '0;
    end else begin
      if (state_reg == CLR) begin
        off_cnt_reg   <= '0;
        eng_out_q_reg <= '0;
      end else if (detect) begin
        eng_out_q_reg <= eng_out;
      end
      // Offset sticks at all-ones on very long packets rather than wrapping.
      if (state_reg == RUN && s_valid && off_cnt_reg != {OFF_W{1'b1}})
        off_cnt_reg <= off_cnt_reg + OFF_W'(1);
      if (state_reg == RUN && s_valid && s_last)
        drain_cnt_reg <= DRAIN_W'(DRAIN_CYC);
      else if (state_reg == DRAIN && drain_cnt_reg != '0)
        drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
    end
  end

  // A bit is never set and granted in the same cycle: each engine rises once per packet.
  for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_eng
    assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~(issue & (gnt_idx == ID_W'(gi))));

    always_ff @(posedge clk) begin
      if (rst)           off_cap_reg[gi] <= '0;
      else if (rise[gi]) off_cap_reg[gi] <= off_cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  nfa_rr_arbiter #(
    .N (NUM_ENG),
    .W (ID_W)
  ) u_arb (
    .req     (pend_reg),
    .ptr     (rr_ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      rep_reg     <= '0;
      rr_ptr_reg  <= '0;
    end else if (load) begin
      m_valid_reg <= gnt_vld;
      if (gnt_vld) begin
        rep_reg.eng_id <= REP_ID_MAX_W'(gnt_idx);
        rep_reg.offset <= REP_OFF_MAX_W'(off_cap_reg[gnt_idx]);
        rr_ptr_reg     <= (gnt_idx == ID_W'(NUM_ENG - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
    end
  end

`ifdef NFA_SEQ_MATCH_CNT_EN
  logic [ID_W:0] match_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)                    match_cnt_reg <= '0;
    else if (state_reg == CLR)  match_cnt_reg <= '0;
    else if (issue)             match_cnt_reg <= match_cnt_reg + (ID_W + 1)'(1);
  end

  assign pkt_match_cnt = match_cnt_reg;
`endif

  assign m_valid         = m_valid_reg;
  assign m_eng_id        = rep_reg.eng_id[ID_W-1:0];
  assign m_offset        = rep_reg.offset[OFF_W-1:0];
  assign busy            = (state_reg != IDLE);
  assign unused_rep_bits = ^rep_reg;

endmodule

// File: tb/tb_nfa_stream_sequencer.sv
// Randomised bench for nfa_stream_sequencer: per packet, the expected report set
// is each triggered engine's trigger offset (saturated); NFA_SEQ_MATCH_CNT_EN optional.
module tb_nfa_stream_sequencer;

  localparam int NUM_ENG   = 8;
  localparam int OFF_W     = 5;
  localparam int DRAIN_CYC = 2;
  localparam int ID_W      = 3;
  localparam int OFF_MAX   = (1 << OFF_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid, s_ready, s_last;
  logic [7:0]         s_data, eng_char;
  logic               eng_sod, eng_en;
  logic [NUM_ENG-1:0] eng_out;
  logic               m_valid, m_ready;
  logic [ID_W-1:0]    m_eng_id;
  logic [OFF_W-1:0]   m_offset;
  logic               pkt_done, busy;
`ifdef NFA_SEQ_MATCH_CNT_EN
  logic [ID_W:0]      pkt_match_cnt;
`endif

  always #5 clk = ~clk;

  nfa_stream_sequencer #(
    .NUM_ENG   (NUM_ENG),
    .OFF_W     (OFF_W),
    .DRAIN_CYC (DRAIN_CYC),
    .ID_W      (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .eng_sod  (eng_sod),
    .eng_en   (eng_en),
    .eng_char (eng_char),
    .eng_out  (eng_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_eng_id (m_eng_id),
    .m_offset (m_offset),
    .pkt_done (pkt_done),
`ifdef NFA_SEQ_MATCH_CNT_EN
    .pkt_match_cnt (pkt_match_cnt),
`endif
    .busy     (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-packet stimulus plan and observations.
  int trig_off [NUM_ENG];
  int got_off  [NUM_ENG];
  int got_id_q [$];
  int got_cyc_q[$];
  int acc_cnt, done_cnt, sod_cnt, drain_cnt, bad_char, bad_run, bad_hold, dup_cnt;
  int match_cnt_seen, cyc;
  bit last_acc, done_mvalid, hold_prev;
  logic [ID_W-1:0]  hold_id;
  logic [OFF_W-1:0] hold_off;

  // Inputs are already driven; sample just after the falling edge, then advance one clock.
  task automatic cycle();
    bit sod_seen;
    #1;
    if (s_valid && s_ready) begin
      acc_cnt++;
      if (s_last) last_acc = 1'b1;
      if (eng_en !== 1'b1 || eng_char !== s_data) bad_run++;
    end
    if (hold_prev && !(m_valid === 1'b1 && m_eng_id === hold_id && m_offset === hold_off)) bad_hold++;
    hold_prev = (m_valid === 1'b1) && !m_ready && !rst;
    hold_id   = m_eng_id;
    hold_off  = m_offset;
    if (m_valid && m_ready) begin
      if (got_off[int'(m_eng_id)] >= 0) dup_cnt++;
      got_off[int'(m_eng_id)] = int'(m_offset);
      got_id_q.push_back(int'(m_eng_id));
      got_cyc_q.push_back(cyc);
    end
    if (pkt_done) begin
      done_cnt++;
      if (m_valid) done_mvalid = 1'b1;
`ifdef NFA_SEQ_MATCH_CNT_EN
      match_cnt_seen = int'(pkt_match_cnt);
`endif
    end
    if (eng_sod) sod_cnt++;
    if (eng_en && !s_ready) begin
      drain_cnt++;
      if (eng_char !== 8'h00) bad_char++;
    end
    sod_seen = eng_sod;
    @(posedge clk);
    @(negedge clk);
    if (sod_seen) eng_out = '0;  // engines clear their sticky flags on sod
    cyc++;
  endtask

  task automatic clear_plan();
    foreach (trig_off[i]) trig_off[i] = -1;
  endtask

  task automatic run_packet(input string name, input int len, input int vpct,
                            input int rpct, input int hold);
    int exp_n, guard, post, exp_o;
    bit raised [NUM_ENG];
    bit was_last;
    acc_cnt = 0; last_acc = 1'b0; done_cnt = 0; sod_cnt = 0; drain_cnt = 0;
    bad_char = 0; bad_run = 0; bad_hold = 0; dup_cnt = 0; done_mvalid = 1'b0;
    match_cnt_seen = -1;
    got_id_q.delete();
    got_cyc_q.delete();
    foreach (got_off[i]) got_off[i] = -1;
    foreach (raised[i]) raised[i] = 1'b0;
    exp_n = 0;
    foreach (trig_off[i]) if (trig_off[i] >= 0) exp_n++;
    post  = 0;
    guard = 0;
    while (done_cnt == 0 && guard < 600) begin
      was_last = last_acc;
      if (!last_acc) begin
        s_valid = ($urandom_range(99) < vpct);
        s_data  = 8'($urandom);
        s_last  = (acc_cnt == len - 1);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        if (!raised[i] && trig_off[i] >= 0 &&
            ((s_ready && !last_acc && trig_off[i] == acc_cnt) ||
             (last_acc && post == 0 && trig_off[i] == len))) begin
          eng_out[i] = 1'b1;
          raised[i]  = 1'b1;
        end
      end
      if (hold > 0 && (!last_acc || post < hold)) m_ready = 1'b0;
      else                                       m_ready = ($urandom_range(99) < rpct);
      if (hold > 0 && last_acc && post == hold) begin
        check({name, "_nodone_in_hold"}, done_cnt, 0);
        check({name, "_mvalid_in_hold"}, m_valid, 1);
        check({name, "_busy_in_hold"}, busy, 1);
      end
      cycle();
      if (was_last) post++;
      guard++;
    end
    check({name, "_no_timeout"}, guard < 600, 1);
    if (guard >= 600) begin
      rst = 1'b1;
      cycle();
      rst = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_sod_cycles"}, sod_cnt, 1);
    check({name, "_drain_cycles"}, drain_cnt, DRAIN_CYC);
    check({name, "_drain_char"}, bad_char, 0);
    check({name, "_run_passthru"}, bad_run, 0);
    check({name, "_hold_stable"}, bad_hold, 0);
    check({name, "_dup_reports"}, dup_cnt, 0);
    check({name, "_mvalid_at_done"}, done_mvalid, 0);
    check({name, "_n_reports"}, got_id_q.size(), exp_n);
    for (int i = 0; i < NUM_ENG; i++) begin
      exp_o = (trig_off[i] < 0) ? -1 : ((trig_off[i] > OFF_MAX) ? OFF_MAX : trig_off[i]);
      check($sformatf("%s_off_eng%0d", name, i), got_off[i], exp_o);
    end
`ifdef NFA_SEQ_MATCH_CNT_EN
    check({name, "_match_cnt"}, match_cnt_seen, exp_n);
`endif
    repeat (3) cycle();
    check({name, "_single_done"}, done_cnt, 1);
    check({name, "_idle_after"}, busy, 0);
    $display("[TB] packet %s len=%0d reports=%0d", name, len, got_id_q.size());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; eng_out = '0; m_ready = 1'b0;
    cyc = 0; hold_prev = 1'b0;
    clear_plan();
    foreach (got_off[i]) got_off[i] = -1;
    @(negedge clk);
    repeat (3) cycle();
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_eng_en", eng_en, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_sod", eng_sod, 1);
    rst = 1'b0;
    cycle();
    check("idle_eng_sod", eng_sod, 0);

    // Single match at offset 4 in a 5-byte packet.
    clear_plan(); trig_off[3] = 4;
    run_packet("single", 5, 100, 100, 0);

    // Move the round-robin pointer to 6, then three simultaneous matches.
    clear_plan(); trig_off[5] = 1;
    run_packet("ptr_setup", 3, 100, 100, 0);
    clear_plan(); trig_off[1] = 7; trig_off[5] = 7; trig_off[6] = 7;
    run_packet("rr_order", 9, 100, 100, 0);
    if (got_id_q.size() == 3) begin
      check("rr_order_first", got_id_q[0], 6);
      check("rr_order_second", got_id_q[1], 1);
      check("rr_order_third", got_id_q[2], 5);
      check("rr_order_consec", got_cyc_q[2] - got_cyc_q[0], 2);
    end

    // Backpressure: report held for 10 cycles in FLUSH.
    clear_plan(); trig_off[2] = 1;
    run_packet("hold", 3, 100, 100, 10);

    // One-byte packet, match appearing during drain.
    clear_plan(); trig_off[0] = 1;
    run_packet("one_byte", 1, 100, 100, 0);

    // Sticky flag from one packet does not carry into the next.
    clear_plan(); trig_off[4] = 2;
    run_packet("sticky_a", 4, 100, 100, 0);
    clear_plan();
    run_packet("sticky_b", 4, 100, 100, 0);
    clear_plan(); trig_off[4] = 3;
    run_packet("sticky_c", 5, 100, 100, 0);

    // Reset mid-packet with every engine pending.
    clear_plan(); done_cnt = 0;
    s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b0;
    repeat (4) cycle();
    s_valid = 1'b0;
    eng_out = '1;
    cycle();
    rst = 1'b1;
    #1;
    check("midrst_eng_sod", eng_sod, 1);
    check("midrst_s_ready", s_ready, 0);
    cycle();
    check("midrst_busy", busy, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_eng_sod_held", eng_sod, 1);
    rst = 1'b0;
    hold_prev = 1'b0;
    m_ready = 1'b1;
    repeat (6) cycle();
    check("midrst_no_done", done_cnt, 0);
    check("midrst_m_valid_after", m_valid, 0);
    check("midrst_idle", busy, 0);

    // Randomised packets with gaps, backpressure and saturating offsets.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(40, 1);
      clear_plan();
      for (int i = 0; i < NUM_ENG; i++)
        if ($urandom_range(1) == 1) trig_off[i] = $urandom_range(len, 0);
      run_packet($sformatf("rand%0d", p), len, $urandom_range(100, 50),
                 $urandom_range(100, 30), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
